fir_gain_cfg_ctrl: RTL and testbench

Configuration sequencer for the `fir_gain` output-gain stage of the 4-to-1 mux FIR path.
- Accepts one {exponent, mantissa} update from the host register interface and shifts it into `fir_gain` as two `firgain_indicator` beats, exponent first.
- Issues `config_sync` only when the I/Q datapath has been quiet long enough that no in-flight sample is processed with a mixed old/new gain. A timeout fallback forces the sync if the datapath never goes quiet.
- Reports completion and holds readback copies of the active gain.

---
 rtl/fir_gain_pkg.sv | 15 +
 rtl/fir_quiet_mon.sv | 27 ++
 rtl/fir_gain_cfg_ctrl.sv | 99 +++++++++
 tb/tb_fir_gain_cfg_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_gain_pkg.sv
// fir_gain_pkg: shared widths, flag pipeline depth and sequencer state encoding for the fir_gain path
package fir_gain_pkg;
    localparam int COEBITWIDTH = 16;
    localparam int MANTBITWIDTH = 16;
    localparam int EXPBITWIDTH = 4;
    localparam int FLAG_PIPE_DEPTH = 7;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_EXP,
        ST_LOAD_MANT,
        ST_WAIT_QUIET,
        ST_SYNC,
        ST_ACK
    } cfg_state_t;
endpackage

// File: rtl/fir_quiet_mon.sv
// fir_quiet_mon: saturating flag-free cycle counter that reports when the I/Q datapath has drained
module fir_quiet_mon
    import fir_gain_pkg::*;
#(
    parameter int QUIET_CYCLES = FLAG_PIPE_DEPTH + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic dataI_flag,
    input  logic dataQ_flag,
    output logic quiet
);
    localparam int QW = $clog2(QUIET_CYCLES + 1);
    logic [QW-1:0] qcnt;
    logic          flag;
    assign flag = dataI_flag || dataQ_flag;
    // Count consecutive flag-free cycles, holding once the pipeline depth plus margin is covered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            qcnt <= '0;
        else if (flag)
            qcnt <= '0;
        else if (qcnt != QW'(QUIET_CYCLES))
            qcnt <= qcnt + QW'(1);
    end
    assign quiet = (qcnt == QW'(QUIET_CYCLES)) && !flag;
endmodule

// File: rtl/fir_gain_cfg_ctrl.sv
// fir_gain_cfg_ctrl: shifts a host {exponent, mantissa} update into fir_gain and syncs it once the datapath is quiet
module fir_gain_cfg_ctrl
    import fir_gain_pkg::*;
#(
    parameter int COEBITWIDTH  = fir_gain_pkg::COEBITWIDTH,
    parameter int MANTBITWIDTH = fir_gain_pkg::MANTBITWIDTH,
    parameter int EXPBITWIDTH  = fir_gain_pkg::EXPBITWIDTH,
    parameter int QUIET_CYCLES = FLAG_PIPE_DEPTH + 1,
    parameter int MAX_WAIT     = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_req,
    input  logic                    cfg_force,
    input  logic [EXPBITWIDTH-1:0]  cfg_exp,
    input  logic [MANTBITWIDTH-1:0] cfg_mant,
    output logic                    cfg_busy,
    output logic                    cfg_ack,
    output logic                    cfg_timeout,
    output logic [EXPBITWIDTH-1:0]  gain_exp_q,
    output logic [MANTBITWIDTH-1:0] gain_mant_q,
    input  logic                    dataI_flag,
    input  logic                    dataQ_flag,
    output logic                    firgain_indicator,
    output logic [COEBITWIDTH-1:0]  firgain_param,
    output logic                    config_sync
);
    localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    cfg_state_t              state, state_d;
    logic [EXPBITWIDTH-1:0]  exp_s;
    logic [MANTBITWIDTH-1:0] mant_s;
    logic                    force_s;
    logic                    to_m;
    logic [WW-1:0]           wcnt;
    logic                    quiet;
    logic                    wait_done;
    fir_quiet_mon #(.QUIET_CYCLES(QUIET_CYCLES)) u_quiet (
        .clk        (clk),
        .rst        (rst),
        .dataI_flag (dataI_flag),
        .dataQ_flag (dataQ_flag),
        .quiet      (quiet)
    );
    assign wait_done = (wcnt == WW'(MAX_WAIT - 1));
    // Next-state decode; requests are only looked at in IDLE
    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:       state_d = cfg_req ? ST_LOAD_EXP : ST_IDLE;
            ST_LOAD_EXP:   state_d = ST_LOAD_MANT;
            ST_LOAD_MANT:  state_d = ST_WAIT_QUIET;
            ST_WAIT_QUIET: state_d = (quiet || force_s || wait_done) ? ST_SYNC : ST_WAIT_QUIET;
            ST_SYNC:       state_d = ST_ACK;
            ST_ACK:        state_d = ST_IDLE;
            default:       state_d = ST_IDLE;
        endcase
    end
    // State, shadows, wait counter and Moore outputs registered from the next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= ST_IDLE;
            exp_s             <= '0;
            mant_s            <= '0;
            force_s           <= 1'b0;
            to_m              <= 1'b0;
            wcnt              <= '0;
            cfg_busy          <= 1'b0;
            cfg_ack           <= 1'b0;
            cfg_timeout       <= 1'b0;
            gain_exp_q        <= '0;
            gain_mant_q       <= '0;
            firgain_indicator <= 1'b0;
            firgain_param     <= '0;
            config_sync       <= 1'b0;
        end else begin
            state <= state_d;
            if (state == ST_IDLE && cfg_req) begin
                exp_s   <= cfg_exp;
                mant_s  <= cfg_mant;
                force_s <= cfg_force;
                to_m    <= 1'b0;
            end
            if (state == ST_WAIT_QUIET && wait_done && !quiet && !force_s)
                to_m <= 1'b1;
            wcnt              <= (state == ST_WAIT_QUIET) ? wcnt + WW'(1) : '0;
            cfg_busy          <= state_d != ST_IDLE;
            cfg_ack           <= state_d == ST_ACK;
            cfg_timeout       <= (state_d == ST_ACK) && to_m;
            firgain_indicator <= (state_d == ST_LOAD_EXP) || (state_d == ST_LOAD_MANT);
            firgain_param     <= (state_d == ST_LOAD_EXP)  ? COEBITWIDTH'(cfg_exp) :
                                 (state_d == ST_LOAD_MANT) ? COEBITWIDTH'(mant_s) : '0;
            config_sync       <= state_d == ST_SYNC;
            if (state_d == ST_SYNC) begin
                gain_exp_q  <= exp_s;
                gain_mant_q <= mant_s;
            end
        end
    end
endmodule

// File: tb/tb_fir_gain_cfg_ctrl.sv
// tb_fir_gain_cfg_ctrl: randomized scenario bench with a cycle-level reference of the config handshake
module tb_fir_gain_cfg_ctrl;
    localparam int QC = 8;
    localparam int MW = 32;
    localparam int NC = 64;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_req = 1'b0;
    logic        cfg_force = 1'b0;
    logic [3:0]  cfg_exp = '0;
    logic [15:0] cfg_mant = '0;
    logic        dI = 1'b0;
    logic        dQ = 1'b0;
    logic        cfg_busy, cfg_ack, cfg_timeout, firgain_indicator, config_sync;
    logic [3:0]  gain_exp_q;
    logic [15:0] gain_mant_q, firgain_param;
    int          n_chk = 0;
    int          n_pass = 0;
    bit          hist[$];
    logic [3:0]  rb_exp = '0;
    logic [15:0] rb_mant = '0;
    logic [15:0] fg_r1, fg_r2, fg_mant;
    logic [3:0]  fg_exp;

    fir_gain_cfg_ctrl #(.QUIET_CYCLES(QC), .MAX_WAIT(MW)) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_req           (cfg_req),
        .cfg_force         (cfg_force),
        .cfg_exp           (cfg_exp),
        .cfg_mant          (cfg_mant),
        .cfg_busy          (cfg_busy),
        .cfg_ack           (cfg_ack),
        .cfg_timeout       (cfg_timeout),
        .gain_exp_q        (gain_exp_q),
        .gain_mant_q       (gain_mant_q),
        .dataI_flag        (dI),
        .dataQ_flag        (dQ),
        .firgain_indicator (firgain_indicator),
        .firgain_param     (firgain_param),
        .config_sync       (config_sync)
    );

    always #5 clk = ~clk;

    // Flag activity per cycle since reset; cycles before reset count as busy
    always @(posedge clk or negedge rst)
        if (!rst) hist.delete();
        else hist.push_back(dI | dQ);

    // Downstream fir_gain parameter registers: two-deep shift, applied on config_sync
    always @(posedge clk or negedge rst)
        if (!rst) begin
            fg_r1 <= '0; fg_r2 <= '0; fg_exp <= '0; fg_mant <= '0;
        end else begin
            if (firgain_indicator) begin fg_r2 <= fg_r1; fg_r1 <= firgain_param; end
            if (config_sync) begin fg_exp <= fg_r2[3:0]; fg_mant <= fg_r1; end
        end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [40:0] act();
        return {cfg_busy, cfg_ack, cfg_timeout, firgain_indicator, firgain_param,
                config_sync, gain_exp_q, gain_mant_q};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request from an IDLE cycle (cycle 0); checks every output each cycle up to the IDLE after ACK
    task automatic run_req(input logic [3:0] e, input logic [15:0] m, input bit frc, input int mode,
                           input bit hold, input logic [3:0] e2, input logic [15:0] m2,
                           input string nm, output int obs_sync);
        bit fi[NC];
        bit fq[NC];
        bit any[NC];
        bit q, to;
        int sync_c, idx, h;
        int stop;
        logic [15:0] pexp;
        logic [40:0] expv;
        stop = $urandom_range(0, 24);
        for (int k = 0; k < NC; k++) begin
            case (mode)
                0: begin fi[k] = 0; fq[k] = 0; end
                1: begin fi[k] = 1; fq[k] = 1; end
                2: begin fi[k] = (k % 8 == 0) && k <= 20; fq[k] = (k % 8 == 4) && k <= 20; end
                default: begin
                    fi[k] = (k < stop) && ($urandom_range(0, 7) == 0);
                    fq[k] = (k < stop) && ($urandom_range(0, 7) == 0);
                end
            endcase
            any[k] = fi[k] | fq[k];
        end
        sync_c = -1;
        to = 0;
        for (int c = 3; c < 3 + MW; c++) begin
            q = 1;
            for (int j = 0; j <= QC; j++) begin
                idx = c - j;
                if (idx >= 0) begin
                    if (any[idx]) q = 0;
                end else begin
                    h = hist.size() + idx;
                    if (h < 0) q = 0;
                    else if (hist[h]) q = 0;
                end
            end
            if (q || frc || (c - 3 == MW - 1)) begin
                sync_c = c + 1;
                to = !q && !frc;
                break;
            end
        end
        obs_sync = -1;
        cfg_req = 1; cfg_exp = e; cfg_mant = m; cfg_force = frc;
        dI = fi[0]; dQ = fq[0];
        for (int k = 1; k <= sync_c + 2; k++) begin
            step();
            if (k == 1) begin
                cfg_force = 0;
                if (hold) begin cfg_exp = e2; cfg_mant = m2; end
                else cfg_req = 0;
            end
            dI = fi[k]; dQ = fq[k];
            if (config_sync && obs_sync < 0) obs_sync = k;
            if (k == sync_c) begin rb_exp = e; rb_mant = m; end
            pexp = (k == 1) ? {12'h000, e} : (k == 2) ? m : 16'h0000;
            expv = {k <= sync_c + 1, k == sync_c + 1, (k == sync_c + 1) && to, k == 1 || k == 2,
                    pexp, k == sync_c, rb_exp, rb_mant};
            n_chk++;
            if (act() !== expv)
                $display("FAIL %s cycle %0d: outputs %h, expected %h", nm, k, act(), expv);
            else n_pass++;
        end
        n_chk++;
        if (fg_exp !== e || fg_mant !== m)
            $display("FAIL %s fir_gain applied: %h/%h, expected %h/%h", nm, fg_exp, fg_mant, e, m);
        else n_pass++;
    endtask

    task automatic quiet_idle(input int n);
        dI = 0; dQ = 0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        #2 rst = 0;
        #1;
        n_chk++;
        if (act() !== 41'h0) $display("FAIL reset_async: outputs %h, expected 0", act());
        else n_pass++;
        repeat (3) step();
        rst = 1;
        n_chk++;
        if (act() !== 41'h0) $display("FAIL reset_release: outputs %h, expected 0", act());
        else n_pass++;
        for (int i = 0; i < 12; i++) begin
            dI = 1'($urandom_range(0, 1)); dQ = 1'($urandom_range(0, 1));
            step();
            n_chk++;
            if (act() !== 41'h0) $display("FAIL reset_idle_flags cycle %0d: outputs %h, expected 0", i, act());
            else n_pass++;
        end
    endtask

    task automatic test_idle_path();
        int s;
        quiet_idle(12);
        run_req(4'd3, 16'h8000, 0, 0, 0, 4'd0, 16'h0, "idle_path", s);
        n_chk++;
        if (s !== 4) $display("FAIL idle_sync_cycle: got %0d, expected 4", s);
        else n_pass++;
    endtask

    task automatic test_flags_stop();
        int s;
        run_req(4'd9, 16'h1234, 0, 2, 0, 4'd0, 16'h0, "flags_stop", s);
        n_chk++;
        if (s <= 20) $display("FAIL flags_stop_sync_after_last_flag: got %0d, expected > 20", s);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int s;
        run_req(4'd7, 16'hbeef, 0, 1, 0, 4'd0, 16'h0, "timeout", s);
        n_chk++;
        if (s !== 3 + MW) $display("FAIL timeout_sync_cycle: got %0d, expected %0d", s, 3 + MW);
        else n_pass++;
    endtask

    task automatic test_force();
        int s;
        run_req(4'd12, 16'h0f0f, 1, 1, 0, 4'd0, 16'h0, "force", s);
        n_chk++;
        if (s !== 4) $display("FAIL force_sync_cycle: got %0d, expected 4", s);
        else n_pass++;
    endtask

    task automatic test_random();
        int s;
        for (int i = 0; i < 8; i++)
            run_req(4'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 3) == 0,
                    3, 0, 4'd0, 16'h0, "random", s);
    endtask

    task automatic test_back_to_back();
        int s;
        run_req(4'd5, 16'haaaa, 0, 3, 1, 4'd10, 16'h5555, "b2b_first", s);
        run_req(4'd10, 16'h5555, 0, 3, 0, 4'd0, 16'h0, "b2b_second", s);
    endtask

    task automatic test_reset_mid();
        cfg_req = 1; cfg_exp = 4'd6; cfg_mant = 16'h4321; dI = 0; dQ = 0;
        step();
        cfg_req = 0;
        step();
        n_chk++;
        if (firgain_indicator !== 1'b1 || firgain_param !== 16'h4321)
            $display("FAIL midreset_load_mant: ind %b param %h, expected 1 4321", firgain_indicator, firgain_param);
        else n_pass++;
        rst = 0;
        #1;
        rb_exp = '0; rb_mant = '0;
        n_chk++;
        if (act() !== 41'h0) $display("FAIL midreset_abort: outputs %h, expected 0", act());
        else n_pass++;
        repeat (2) step();
        rst = 1;
        for (int i = 0; i < 14; i++) begin
            step();
            n_chk++;
            if (act() !== 41'h0) $display("FAIL midreset_after cycle %0d: outputs %h, expected 0", i, act());
            else n_pass++;
        end
        n_chk++;
        if (fg_exp !== 4'd0 || fg_mant !== 16'h0)
            $display("FAIL midreset_fir_gain: %h/%h, expected 0/0", fg_exp, fg_mant);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_idle_path();
        test_flags_stop();
        test_timeout();
        test_force();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
